ethernet_header_transmitter: RTL and testbench

Transmit-side counterpart of the header receiver. It takes a 42-byte Ethernet+IPv4+UDP header (14+20+8 bytes) as one parallel word, plus a payload AXI-Stream. It emits a single 64-bit AXI-Stream frame: 5 full header beats, then a merged beat holding the last 2 header bytes and the first 6 payload bytes, then the payload shifted by 2 bytes. It sits between the packet builder and the 10G MAC TX AXIS interface.

---
 rtl/eth_tx_pkg.sv | 32 +++
 rtl/eth_tx_shift2.sv | 40 ++++
 rtl/ethernet_header_transmitter.sv | 175 +++++++++++++++++
 tb/tb_ethernet_header_transmitter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_pkg.sv
// Shared constants, FSM encoding and keep/count helpers for the Ethernet header transmitter.
package eth_tx_pkg;

  localparam int HEAD_BYTES = 42;
  localparam int HEAD_W     = HEAD_BYTES * 8;
  localparam int AXIS_W     = 64;
  localparam int KEEP_W     = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HEAD  = 3'd1,
    MERGE = 3'd2,
    BODY  = 3'd3,
    TAIL  = 3'd4
  } tx_state_t;

  function automatic logic [3:0] keep_to_count(input logic [KEEP_W-1:0] keep);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < KEEP_W; i++) begin
      cnt = cnt + {3'd0, keep[i]};
    end
    return cnt;
  endfunction

  function automatic logic [KEEP_W-1:0] count_to_keep(input logic [3:0] cnt);
    logic [KEEP_W:0] mask;
    mask = (9'd1 << cnt) - 9'd1;
    return mask[KEEP_W-1:0];
  endfunction

endpackage

// File: rtl/eth_tx_shift2.sv
// Splices the 2-byte residual under the next payload beat and decides how the frame ends.
module eth_tx_shift2
  import eth_tx_pkg::*;
(
  input  logic [15:0]        i_res,
  input  logic [AXIS_W-1:0]  i_pl_tdata,
  input  logic [KEEP_W-1:0]  i_pl_tkeep,
  input  logic               i_pl_tlast,
  output logic [AXIS_W-1:0]  o_tdata,
  output logic [KEEP_W-1:0]  o_tkeep,
  output logic               o_tlast,
  output logic               o_tail_needed,
  output logic [15:0]        o_res_next,
  output logic [1:0]         o_r_next
);

  logic [3:0] w_n;

  assign w_n        = keep_to_count(i_pl_tkeep);
  assign o_tdata    = {i_pl_tdata[AXIS_W-17:0], i_res};
  assign o_res_next = i_pl_tdata[AXIS_W-1:AXIS_W-16];

  // A last beat of up to 6 bytes fits together with the residual; 7 or 8 spill into a tail beat.
  always_comb begin
    o_tkeep       = '1;
    o_tlast       = 1'b0;
    o_tail_needed = 1'b0;
    o_r_next      = 2'd2;
    if (i_pl_tlast) begin
      if (w_n <= 4'd6) begin
        o_tkeep = count_to_keep(w_n + 4'd2);
        o_tlast = 1'b1;
      end else begin
        o_tail_needed = 1'b1;
        o_r_next      = 2'(w_n - 4'd6);
      end
    end
  end

endmodule

// File: rtl/ethernet_header_transmitter.sv
// Prepends a 42-byte parallel header to a payload AXI-Stream and emits one 64-bit frame
// through a registered, back-pressurable output stage.
module ethernet_header_transmitter
  import eth_tx_pkg::*;
#(
  parameter int IFG_CYCLES = 0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_head_valid,
  input  logic [HEAD_W-1:0]  i_data_head,
  output logic               o_head_ready,
  input  logic               i_pl_axis_tvalid,
  input  logic [AXIS_W-1:0]  i_pl_axis_tdata,
  input  logic               i_pl_axis_tlast,
  input  logic [KEEP_W-1:0]  i_pl_axis_tkeep,
  output logic               o_pl_axis_tready,
  output logic               o_tx_axis_tvalid,
  output logic [AXIS_W-1:0]  o_tx_axis_tdata,
  output logic               o_tx_axis_tlast,
  output logic [KEEP_W-1:0]  o_tx_axis_tkeep,
  input  logic               i_tx_axis_tready
);

  localparam logic [15:0] GAP_INIT = (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;
  localparam logic        GAP_EN   = (IFG_CYCLES != 0);

  tx_state_t           r_state, w_state_next;
  logic [HEAD_W-1:0]   r_hdr;
  logic [2:0]          r_k;
  logic [15:0]         r_res;
  logic [1:0]          r_r;
  logic [15:0]         r_gap_left;
  logic                r_tvalid, r_tlast;
  logic [AXIS_W-1:0]   r_tdata;
  logic [KEEP_W-1:0]   r_tkeep;

  logic                w_adv, w_tx_fire, w_gap_ok, w_head_fire, w_pl_fire;
  logic                w_tvalid_next, w_tlast_next;
  logic [AXIS_W-1:0]   w_tdata_next, w_head_beat, w_sh_tdata;
  logic [KEEP_W-1:0]   w_tkeep_next, w_sh_tkeep;
  logic                w_sh_tlast, w_sh_tail;
  logic [15:0]         w_sh_res;
  logic [1:0]          w_sh_r;

  assign w_adv       = ~r_tvalid | i_tx_axis_tready;
  assign w_tx_fire   = r_tvalid & i_tx_axis_tready;
  // A pending tlast beat blocks the next header unless no gap is required at all.
  assign w_gap_ok    = (r_gap_left == 16'd0) & ~(GAP_EN & r_tvalid & r_tlast);
  assign o_head_ready     = ~i_reset & (r_state == IDLE) & w_gap_ok & w_adv;
  assign o_pl_axis_tready = ~i_reset & ((r_state == MERGE) | (r_state == BODY)) & w_adv;
  assign w_head_fire = i_head_valid & o_head_ready;
  assign w_pl_fire   = i_pl_axis_tvalid & o_pl_axis_tready;

  assign o_tx_axis_tvalid = r_tvalid;
  assign o_tx_axis_tdata  = r_tdata;
  assign o_tx_axis_tlast  = r_tlast;
  assign o_tx_axis_tkeep  = r_tkeep;

  // r_hdr shifts up one beat per HEAD cycle, so the current beat always sits in the top 8 bytes.
  generate
    for (genvar gi = 0; gi < KEEP_W; gi++) begin : g_head_bytes
      assign w_head_beat[8*gi +: 8] = r_hdr[HEAD_W-1-8*gi -: 8];
    end
  endgenerate

  eth_tx_shift2 u_shift2 (
    .i_res         (r_res),
    .i_pl_tdata    (i_pl_axis_tdata),
    .i_pl_tkeep    (i_pl_axis_tkeep),
    .i_pl_tlast    (i_pl_axis_tlast),
    .o_tdata       (w_sh_tdata),
    .o_tkeep       (w_sh_tkeep),
    .o_tlast       (w_sh_tlast),
    .o_tail_needed (w_sh_tail),
    .o_res_next    (w_sh_res),
    .o_r_next      (w_sh_r)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else if (w_adv) begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:        if (w_head_fire) w_state_next = HEAD;
      HEAD:        if (r_k == 3'd4) w_state_next = MERGE;
      MERGE, BODY: if (w_pl_fire) w_state_next = w_sh_tlast ? IDLE : (w_sh_tail ? TAIL : BODY);
      TAIL:        w_state_next = IDLE;
      default:     w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_tvalid_next = 1'b0;
    w_tdata_next  = r_tdata;
    w_tkeep_next  = '0;
    w_tlast_next  = 1'b0;
    case (r_state)
      HEAD: begin
        w_tvalid_next = 1'b1;
        w_tdata_next  = w_head_beat;
        w_tkeep_next  = '1;
      end
      MERGE, BODY: begin
        if (w_pl_fire) begin
          w_tvalid_next = 1'b1;
          w_tdata_next  = w_sh_tdata;
          w_tkeep_next  = w_sh_tkeep;
          w_tlast_next  = w_sh_tlast;
        end
      end
      TAIL: begin
        w_tvalid_next = 1'b1;
        w_tdata_next  = {{(AXIS_W-16){1'b0}}, r_res};
        w_tkeep_next  = count_to_keep({2'b00, r_r});
        w_tlast_next  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hdr      <= '0;
      r_k        <= '0;
      r_res      <= '0;
      r_r        <= '0;
      r_gap_left <= '0;
      r_tvalid   <= 1'b0;
      r_tdata    <= '0;
      r_tkeep    <= '0;
      r_tlast    <= 1'b0;
    end else begin
      if (w_tx_fire && r_tlast) begin
        r_gap_left <= GAP_INIT;
      end else if (r_gap_left != 16'd0) begin
        r_gap_left <= r_gap_left - 16'd1;
      end
      if (w_adv) begin
        r_tvalid <= w_tvalid_next;
        r_tdata  <= w_tdata_next;
        r_tkeep  <= w_tkeep_next;
        r_tlast  <= w_tlast_next;
        case (r_state)
          IDLE: begin
            if (w_head_fire) begin
              r_hdr <= i_data_head;
              r_k   <= 3'd0;
            end
          end
          HEAD: begin
            r_hdr <= r_hdr << AXIS_W;
            r_k   <= r_k + 3'd1;
            // Header bytes 40 and 41 seed the residual that the merged beat places lowest.
            if (r_k == 3'd4) r_res <= {r_hdr[HEAD_W-AXIS_W-9 -: 8], r_hdr[HEAD_W-AXIS_W-1 -: 8]};
          end
          MERGE, BODY: begin
            if (w_pl_fire) begin
              r_res <= w_sh_res;
              r_r   <= w_sh_r;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ethernet_header_transmitter.sv
// Directed bench: frames are modelled as header++payload byte lists chunked into 8-byte beats.
module tb_ethernet_header_transmitter;

  localparam int IFG = 3;

  logic         i_clk = 1'b0;
  logic         i_reset = 1'b1;
  logic         i_head_valid = 1'b0;
  logic [335:0] i_data_head = '0;
  logic         o_head_ready;
  logic         i_pl_axis_tvalid = 1'b0;
  logic [63:0]  i_pl_axis_tdata = '0;
  logic         i_pl_axis_tlast = 1'b0;
  logic [7:0]   i_pl_axis_tkeep = '0;
  logic         o_pl_axis_tready;
  logic         o_tx_axis_tvalid;
  logic [63:0]  o_tx_axis_tdata;
  logic         o_tx_axis_tlast;
  logic [7:0]   o_tx_axis_tkeep;
  logic         i_tx_axis_tready = 1'b1;

  always #5 i_clk = ~i_clk;

  ethernet_header_transmitter #(.IFG_CYCLES(IFG)) dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_head_valid     (i_head_valid),
    .i_data_head      (i_data_head),
    .o_head_ready     (o_head_ready),
    .i_pl_axis_tvalid (i_pl_axis_tvalid),
    .i_pl_axis_tdata  (i_pl_axis_tdata),
    .i_pl_axis_tlast  (i_pl_axis_tlast),
    .i_pl_axis_tkeep  (i_pl_axis_tkeep),
    .o_pl_axis_tready (o_pl_axis_tready),
    .o_tx_axis_tvalid (o_tx_axis_tvalid),
    .o_tx_axis_tdata  (o_tx_axis_tdata),
    .o_tx_axis_tlast  (o_tx_axis_tlast),
    .o_tx_axis_tkeep  (o_tx_axis_tkeep),
    .i_tx_axis_tready (i_tx_axis_tready)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  int n_checks = 0;
  int n_fail = 0;
  int stall_mode = 0;
  logic in_reset = 1'b1;

  beat_t exp_q[$];
  logic [7:0] cur_hdr[42];
  logic [7:0] cur_pl[$];

  int frame_beats = 0;
  int frames_done = 0;
  logic [63:0] log_data[32], done_data[32];
  logic [7:0]  log_keep[32], done_keep[32];
  logic        log_last[32], done_last[32];
  int done_beats = 0;
  logic [7:0] frame_bytes[$], last_bytes[$], ref_bytes[$];
  logic gap_track = 1'b0;
  int idle_cnt = 0;
  logic prev_stall = 1'b0;
  logic [73:0] prev_bundle = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] keep_mask(input logic [7:0] k);
    logic [63:0] m;
    for (int j = 0; j < 8; j++) m[8*j +: 8] = {8{k[j]}};
    return m;
  endfunction

  // Model: the frame is simply header bytes followed by payload bytes, cut into 8-byte beats.
  function automatic void push_model();
    logic [7:0] all[$];
    int nb;
    all = {};
    for (int i = 0; i < 42; i++) all.push_back(cur_hdr[i]);
    foreach (cur_pl[i]) all.push_back(cur_pl[i]);
    nb = all.size();
    for (int s = 0; s < nb; s += 8) begin
      beat_t b;
      b.data = '0;
      b.keep = '0;
      for (int j = 0; j < 8; j++) begin
        if (s + j < nb) begin
          b.data[8*j +: 8] = all[s+j];
          b.keep[j] = 1'b1;
        end
      end
      b.last = (s + 8 >= nb);
      exp_q.push_back(b);
    end
  endfunction

  function automatic void set_header(input logic [7:0] base);
    for (int i = 0; i < 42; i++) cur_hdr[i] = base + 8'(i);
  endfunction

  function automatic void set_payload(input int len, input logic [7:0] base);
    cur_pl = {};
    for (int i = 0; i < len; i++) cur_pl.push_back(base + 8'(i));
  endfunction

  always @(negedge i_clk) begin
    if (in_reset) begin
      exp_q.delete();
      frame_beats = 0;
      frame_bytes.delete();
      gap_track = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {54'd0, o_tx_axis_tvalid, o_tx_axis_tlast, o_tx_axis_tkeep, o_tx_axis_tdata},
              {54'd0, prev_bundle});
      if (o_tx_axis_tvalid) begin
        if (gap_track) begin
          check("ifg_gap_ok", {127'd0, (idle_cnt >= IFG)}, 128'd1);
          gap_track = 1'b0;
        end
      end else if (gap_track) begin
        idle_cnt++;
      end
      if (o_tx_axis_tvalid && i_tx_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got tdata %h, no beat required", o_tx_axis_tdata);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("tdata", {64'd0, o_tx_axis_tdata & keep_mask(e.keep)}, {64'd0, e.data});
          check("tkeep", {120'd0, o_tx_axis_tkeep}, {120'd0, e.keep});
          check("tlast", {127'd0, o_tx_axis_tlast}, {127'd0, e.last});
        end
        if (frame_beats < 32) begin
          log_data[frame_beats] = o_tx_axis_tdata;
          log_keep[frame_beats] = o_tx_axis_tkeep;
          log_last[frame_beats] = o_tx_axis_tlast;
        end
        frame_beats++;
        for (int j = 0; j < 8; j++)
          if (o_tx_axis_tkeep[j]) frame_bytes.push_back(o_tx_axis_tdata[8*j +: 8]);
        if (o_tx_axis_tlast) begin
          done_data = log_data;
          done_keep = log_keep;
          done_last = log_last;
          done_beats = frame_beats;
          frame_beats = 0;
          last_bytes = frame_bytes;
          frame_bytes = {};
          frames_done++;
          gap_track = 1'b1;
          idle_cnt = 0;
        end
      end
      prev_stall = o_tx_axis_tvalid && !i_tx_axis_tready;
      prev_bundle = {o_tx_axis_tvalid, o_tx_axis_tlast, o_tx_axis_tkeep, o_tx_axis_tdata};
    end
  end

  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      i_tx_axis_tready = (stall_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic drive_header();
    logic ok;
    ok = 1'b0;
    @(posedge i_clk);
    #1;
    for (int b = 0; b < 42; b++) i_data_head[335-8*b -: 8] = cur_hdr[b];
    i_head_valid = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      @(negedge i_clk);
      if (o_head_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge i_clk);
    #1;
    i_head_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL head_accept_timeout: got no o_head_ready, required acceptance");
    end
  endtask

  task automatic drive_payload(input int stall);
    int nb;
    int idx;
    logic ok;
    nb = cur_pl.size();
    idx = 0;
    @(posedge i_clk);
    #1;
    while (idx < nb) begin
      if (stall != 0 && $urandom_range(0, 2) == 0) begin
        i_pl_axis_tvalid = 1'b0;
        @(posedge i_clk);
        #1;
        continue;
      end
      i_pl_axis_tdata = '0;
      i_pl_axis_tkeep = '0;
      for (int j = 0; j < 8; j++) begin
        if (idx + j < nb) begin
          i_pl_axis_tdata[8*j +: 8] = cur_pl[idx+j];
          i_pl_axis_tkeep[j] = 1'b1;
        end
      end
      i_pl_axis_tlast = (idx + 8 >= nb);
      i_pl_axis_tvalid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 1000; t++) begin
        @(negedge i_clk);
        if (o_pl_axis_tready) begin
          ok = 1'b1;
          break;
        end
      end
      @(posedge i_clk);
      #1;
      if (!ok) begin
        n_checks++;
        n_fail++;
        $display("FAIL payload_timeout: got no o_pl_axis_tready, required acceptance");
        break;
      end
      idx += 8;
    end
    i_pl_axis_tvalid = 1'b0;
    i_pl_axis_tlast = 1'b0;
  endtask

  task automatic send_frame(input int stall);
    int fd0;
    fd0 = frames_done;
    push_model();
    stall_mode = stall;
    fork
      drive_header();
      drive_payload(stall);
    join
    for (int t = 0; t < 5000 && frames_done == fd0; t++) @(posedge i_clk);
    stall_mode = 0;
    check("frame_done", {127'd0, (frames_done != fd0)}, 128'd1);
    check("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("frame %0d: %0d payload bytes, %0d beats out", frames_done, cur_pl.size(), done_beats);
  endtask

  initial begin
    logic seen_ready;
    int diffs;

    repeat (3) @(posedge i_clk);
    #1;
    check("rst_tvalid", {127'd0, o_tx_axis_tvalid}, 128'd0);
    check("rst_tkeep", {120'd0, o_tx_axis_tkeep}, 128'd0);
    check("rst_tlast", {127'd0, o_tx_axis_tlast}, 128'd0);
    check("rst_tdata", {64'd0, o_tx_axis_tdata}, 128'd0);
    check("rst_head_ready", {127'd0, o_head_ready}, 128'd0);
    check("rst_pl_tready", {127'd0, o_pl_axis_tready}, 128'd0);
    i_reset = 1'b0;
    in_reset = 1'b0;

    // Payload offered before any header must not be taken.
    i_pl_axis_tvalid = 1'b1;
    i_pl_axis_tkeep = 8'hFF;
    seen_ready = 1'b0;
    repeat (5) begin
      @(negedge i_clk);
      seen_ready |= o_pl_axis_tready;
    end
    @(posedge i_clk);
    #1;
    i_pl_axis_tvalid = 1'b0;
    check("early_pl_tready", {127'd0, seen_ready}, 128'd0);

    set_header(8'h00);
    set_payload(6, 8'hA0);
    send_frame(0);
    check("f1_beats", 128'(done_beats), 128'd6);
    check("f1_beat0", {64'd0, done_data[0]}, {64'd0, 64'h0706050403020100});
    check("f1_beat5", {64'd0, done_data[5]}, {64'd0, 64'hA5A4A3A2A1A02928});
    check("f1_keep5", {120'd0, done_keep[5]}, {120'd0, 8'hFF});
    check("f1_last5", {127'd0, done_last[5]}, 128'd1);

    set_payload(1, 8'hA0);
    send_frame(0);
    check("f2_beats", 128'(done_beats), 128'd6);
    check("f2_tail", {104'd0, done_data[5][23:0]}, {104'd0, 24'hA02928});
    check("f2_keep5", {120'd0, done_keep[5]}, {120'd0, 8'h07});

    set_payload(7, 8'hA0);
    send_frame(0);
    check("f3_beats", 128'(done_beats), 128'd7);
    check("f3_keep6", {120'd0, done_keep[6]}, {120'd0, 8'h01});
    check("f3_byte6", {120'd0, done_data[6][7:0]}, {120'd0, 8'hA6});
    check("f3_last6", {127'd0, done_last[6]}, 128'd1);

    set_payload(16, 8'hA0);
    send_frame(0);
    check("f4_beats", 128'(done_beats), 128'd8);
    check("f4_keep6", {120'd0, done_keep[6]}, {120'd0, 8'hFF});
    check("f4_last6", {127'd0, done_last[6]}, 128'd0);
    check("f4_keep7", {120'd0, done_keep[7]}, {120'd0, 8'h03});
    check("f4_data7", {112'd0, done_data[7][15:0]}, {112'd0, 16'hAFAE});
    check("f4_last7", {127'd0, done_last[7]}, 128'd1);

    set_payload(100, 8'h10);
    send_frame(0);
    ref_bytes = last_bytes;
    send_frame(1);
    diffs = 0;
    if (last_bytes.size() != ref_bytes.size()) diffs = 1000;
    else foreach (ref_bytes[i]) if (last_bytes[i] !== ref_bytes[i]) diffs++;
    check("stall_stream_equal", 128'(diffs), 128'd0);
    check("stall_stream_len", 128'(last_bytes.size()), 128'd142);

    // Reset while beat 3 of a frame is on the output.
    set_header(8'h80);
    set_payload(6, 8'hC0);
    push_model();
    drive_header();
    i_pl_axis_tdata = 64'h0000C5C4C3C2C1C0;
    i_pl_axis_tkeep = 8'h3F;
    i_pl_axis_tlast = 1'b1;
    i_pl_axis_tvalid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(posedge i_clk);
      #2;
      if (o_tx_axis_tvalid && frame_beats == 3) break;
    end
    check("rst_at_beat3", 128'(frame_beats), 128'd3);
    in_reset = 1'b1;
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    check("midrst_tvalid", {127'd0, o_tx_axis_tvalid}, 128'd0);
    check("midrst_tkeep", {120'd0, o_tx_axis_tkeep}, 128'd0);
    i_reset = 1'b0;
    i_pl_axis_tvalid = 1'b0;
    i_pl_axis_tlast = 1'b0;
    @(negedge i_clk);
    @(posedge i_clk);
    #1;
    in_reset = 1'b0;
    $display("mid-frame reset applied at beat 3");

    set_header(8'h00);
    set_payload(6, 8'hA0);
    send_frame(0);
    check("post_rst_beats", 128'(done_beats), 128'd6);
    check("post_rst_beat0", {64'd0, done_data[0]}, {64'd0, 64'h0706050403020100});
    check("post_rst_beat5", {64'd0, done_data[5]}, {64'd0, 64'hA5A4A3A2A1A02928});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
